// File: rtl/sram22_port_ctrl.sv
// sram22_port_ctrl: single-port SRAM controller with a zero-fill sweep.
//
// Requests (read or write) arrive on a valid/ready port and are forwarded
// combinationally to the SRAM macro. Read data comes back from the macro one
// cycle after the read is sampled. It is parked in a 2-entry response FIFO
// and leaves on a valid/ready response port.
// A zero-fill sweep (CLEAR) writes 0 to every address. It runs on reset
// release when INIT_ON_RESET=1, and on a clear_start pulse.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge
// where valid && ready. The producer holds its payload stable while
// valid && !ready.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           request handshake
//   req_we/req_addr/req_wdata     request payload (1 = write)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata                     read data (FIFO head)
//   clear_start                   pulse: start a zero-fill
//   busy                          high while the zero-fill runs (state == CLEAR)
//   clear_done                    one-cycle pulse in the first RUN cycle after a fill
//   sram_we/sram_wmask/sram_addr/sram_din  macro drive
//   sram_dout                     macro read data (one cycle after the read)
module sram22_port_ctrl #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  sram_we,
  output logic [0:0]            sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  localparam state_e                RESET_STATE = INIT_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          clr_cnt_q, clr_cnt_d;
  logic                           inflight_q, inflight_d;
  logic                           clear_done_q, clear_done_d;
  logic [1:0][DATA_WIDTH-1:0]     fifo_mem_q, fifo_mem_d;
  logic                           rd_ptr_q, rd_ptr_d;
  logic                           wr_ptr_q, wr_ptr_d;
  logic [1:0]                     count_q, count_d;

  logic credit_ok;
  logic req_fire;
  logic rsp_fire;
  logic push;

  // Credit covers both stored entries and the read whose data is still on its
  // way from the macro, so a capture always finds a free slot. Only registered
  // state is used: a pop frees its credit from the next cycle on.
  assign credit_ok  = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2;
  // rst gating keeps the port quiet while reset is held, whatever the reset state.
  assign req_ready  = !rst && (state_q == ST_RUN) && credit_ok;
  assign busy       = !rst && (state_q == ST_CLEAR);
  assign req_fire   = req_valid && req_ready;
  assign rsp_valid  = (count_q != 2'd0);
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign rsp_rdata  = fifo_mem_q[rd_ptr_q];
  assign clear_done = clear_done_q;
  // The macro delivers read data in the cycle after the read was sampled.
  assign push       = inflight_q;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clear_done_d = 1'b0;
    inflight_d   = req_fire && !req_we;
    sram_we      = 1'b0;
    sram_wmask   = 1'b0;
    sram_addr    = req_addr;
    sram_din     = req_wdata;

    case (state_q)
      ST_CLEAR: begin
        sram_we    = 1'b1;
        sram_wmask = 1'b1;
        sram_addr  = clr_cnt_q;
        sram_din   = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d      = ST_RUN;
          clear_done_d = 1'b1;
          clr_cnt_d    = '0;
        end
      end
      default: begin
        sram_we    = req_fire && req_we;
        sram_wmask = req_fire;
        // A read still waiting for its macro data would be lost, so the fill waits.
        if (clear_start && !inflight_q) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase

    if (rst) begin
      sram_we    = 1'b0;
      sram_wmask = 1'b0;
    end
  end

  // Response FIFO: responses stay drainable in any state.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = sram_dout;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (rsp_fire) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, rsp_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      clr_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      clear_done_q <= 1'b0;
      fifo_mem_q   <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      inflight_q   <= inflight_d;
      clear_done_q <= clear_done_d;
      fifo_mem_q   <= fifo_mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_sram22_port_ctrl.sv
// Bench for sram22_port_ctrl (ADDR_WIDTH=12, DATA_WIDTH=8, INIT_ON_RESET=1).
// Holds a behavioural SRAM macro, a reference model and a compare process
// that checks the DUT outputs on every falling clock edge. Directed sequences
// also check hand-computed literal values.
module tb_sram22_port_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          clear_start;
  logic          busy;
  logic          clear_done;
  logic          sram_we;
  logic [0:0]    sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  int total;
  int bad;

  sram22_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM macro model ----------------
  logic [DW-1:0] sram_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) sram_mem[i] = DW'($urandom_range(1, 255));
  end
  always @(posedge clk) begin
    if (sram_we && sram_wmask[0]) sram_mem[sram_addr] <= sram_din;
    sram_dout <= sram_mem[sram_addr];
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] exp_q[$];   // expected response data, request order
  int            rdy_q[$];   // cycle at which each response becomes visible
  bit            m_clear;
  int            m_clr_addr;
  bit            m_done_now;
  int            m_out;      // reads accepted and not yet popped
  bit            m_prev_rd;  // a read was accepted in the previous cycle
  int            cyc;
  int            n_pops;
  int            n_nonzero;

  initial begin
    bit e_ready, e_rv, acc, pop, acc_rd;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    cyc = 0; n_pops = 0; n_nonzero = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_wmask", sram_wmask, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_clear_done", clear_done, 0);
        m_clear = 1; m_clr_addr = 0; m_done_now = 0; m_out = 0; m_prev_rd = 0;
        exp_q.delete(); rdy_q.delete();
      end else begin
        e_ready = !m_clear && (m_out < 2);
        e_rv    = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
        check("busy", busy, m_clear);
        check("req_ready", req_ready, e_ready);
        check("rsp_valid", rsp_valid, e_rv);
        check("clear_done", clear_done, m_done_now);
        if (e_rv) check("rsp_rdata", rsp_rdata, exp_q[0]);
        acc    = req_valid && e_ready;
        acc_rd = acc && !req_we;
        if (m_clear) begin
          check("clr_sram_we", sram_we, 1);
          check("clr_sram_wmask", sram_wmask, 1);
          check("clr_sram_din", sram_din, 0);
          check("clr_sram_addr", sram_addr, m_clr_addr);
        end else begin
          check("run_sram_we", sram_we, acc && req_we);
          check("run_sram_wmask", sram_wmask, acc);
          if (acc) begin
            check("run_sram_addr", sram_addr, req_addr);
            check("run_sram_din", sram_din, req_wdata);
          end
        end
        pop = e_rv && rsp_ready;
        // advance to next cycle
        m_done_now = 0;
        if (m_clear) begin
          if (m_clr_addr == DEPTH - 1) begin
            m_clear = 0;
            m_done_now = 1;
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
          end else begin
            m_clr_addr++;
          end
        end else if (clear_start && !m_prev_rd) begin
          m_clear = 1;
          m_clr_addr = 0;
        end
        if (acc && req_we) exp_mem[req_addr] = req_wdata;
        if (acc_rd) begin
          exp_q.push_back(exp_mem[req_addr]);
          rdy_q.push_back(cyc + 2);
        end
        if (pop) begin
          n_pops++;
          if (rsp_rdata != 0) n_nonzero++;
          void'(exp_q.pop_front());
          void'(rdy_q.pop_front());
        end
        m_out     = m_out + (acc_rd ? 1 : 0) - (pop ? 1 : 0);
        m_prev_rd = acc_rd;
      end
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that took the request.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("send_accept", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // First sampled cycle must be the first fill cycle.
  task automatic wait_clear(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check({name, "_len"}, n, DEPTH);
    check({name, "_done"}, clear_done, 1);
    check({name, "_ready"}, req_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, z0;
    bit hs;
    total = 0; bad = 0;
    rst = 1'b1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; clear_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset-release fill
    wait_clear("init_clear");
    step();

    // write then read same address on the next cycle
    send(1'b1, 12'h123, 8'hA5);
    send(1'b0, 12'h123, 8'h00);
    @(negedge clk);
    check("wr_rd_early", rsp_valid, 0);
    step();
    @(negedge clk);
    check("wr_rd_valid", rsp_valid, 1);
    check("wr_rd_data", rsp_rdata, 8'hA5);
    repeat (4) step();

    // credit limit with a stalled consumer
    send(1'b1, 12'h001, 8'h11);
    send(1'b1, 12'h002, 8'h22);
    send(1'b1, 12'h003, 8'h33);
    rsp_ready = 1'b0;
    send(1'b0, 12'h001, 8'h00);
    send(1'b0, 12'h002, 8'h00);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h003;
    repeat (3) begin
      @(negedge clk);
      check("full_ready_low", req_ready, 0);
      check("full_head", rsp_rdata, 8'h11);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_ready_low", req_ready, 0);
    check("pop_cycle_head", rsp_rdata, 8'h11);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("after_pop_ready", req_ready, 1);
    check("after_pop_head", rsp_rdata, 8'h22);
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("drain_head2", rsp_rdata, 8'h22);
    step();
    @(negedge clk);
    check("drain_head3_valid", rsp_valid, 1);
    check("drain_head3", rsp_rdata, 8'h33);
    repeat (4) step();

    // randomized traffic with a toggling consumer
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hs = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (!req_valid || hs) begin
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, 31));
        req_wdata = DW'($urandom_range(0, 255));
      end
      rsp_ready = 1'($urandom_range(0, 2) != 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) step();

    // clear_start with a read in flight is dropped
    send(1'b1, 12'hFFF, 8'hFF);
    send(1'b0, 12'h010, 8'h00);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    @(negedge clk);
    check("clear_ignored_busy", busy, 0);
    repeat (4) step();

    // idle clear, then read every address back
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    wait_clear("idle_clear");
    step();
    p0 = n_pops;
    z0 = n_nonzero;
    for (int a = 0; a < DEPTH; a++) send(1'b0, AW'(a), 8'h00);
    repeat (6) step();
    check("readback_count", n_pops - p0, DEPTH);
    check("readback_nonzero", n_nonzero - z0, 0);

    // reset in the middle of a fill
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12'h800) @(posedge clk);
    #1;
    check("mid_clear_addr", sram_addr, 12'h800);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_we", sram_we, 0);
    check("async_rst_ready", req_ready, 0);
    check("async_rst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("restart_busy", busy, 1);
    check("restart_addr", sram_addr, 0);
    wait_clear("restart_clear");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram22_port_ctrl.md
SRAM22_PORT_CTRL -- requirements
Module: sram22_port_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SRAM address width; depth = 1<<ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8, SRAM word width.
REQ-003 Parameter INIT_ON_RESET, default 1, 1 = zero-fill the entire SRAM on reset release.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request offered.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_WIDTH  request address.
REQ-010 req_wdata  in  DATA_WIDTH  write data.
REQ-011 rsp_valid  out  1  read data available.
REQ-012 rsp_ready  in  1  consumer takes data when rsp_valid && rsp_ready.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data.
REQ-014 clear_start  in  1  single-cycle pulse requesting a zero-fill.
REQ-015 busy  out  1  high while a zero-fill is in progress.
REQ-016 clear_done  out  1  one-cycle pulse when a zero-fill completes.
REQ-017 sram_we / sram_wmask[0] / sram_addr / sram_din  out  1/1/ADDR_WIDTH/DATA_WIDTH  drive the SRAM macro port.
REQ-018 sram_dout  in  DATA_WIDTH  SRAM read data, valid the cycle after the read is sampled.

Function
REQ-019 States SHALL be CLEAR and RUN; reset enters CLEAR if INIT_ON_RESET=1, else RUN.
REQ-020 In CLEAR, the block SHALL drive sram_we=1, sram_wmask=1, sram_din=0, and sram_addr=clear counter; the counter starts at 0 and increments by 1 per cycle.
REQ-021 When the clear counter is at (1<<ADDR_WIDTH)-1, the block SHALL write that address, then move to RUN and pulse clear_done in the first RUN cycle; a clear lasts exactly 1<<ADDR_WIDTH cycles.
REQ-022 busy SHALL equal (state==CLEAR); req_ready SHALL be 0 in CLEAR.
REQ-023 clear_start in RUN SHALL be honoured only when no read is in flight; it enters CLEAR on the next edge with the counter at 0.
REQ-024 clear_start SHALL be ignored when a read is in flight or when already in CLEAR.
REQ-025 Responses already in the FIFO SHALL stay drainable during CLEAR.
REQ-026 In RUN, for an accepted request, sram_addr=req_addr, sram_we=req_we, sram_wmask=1 and sram_din=req_wdata SHALL be driven combinationally in the same cycle.
REQ-027 In RUN with no request accepted, sram_we and sram_wmask SHALL be 0.
REQ-028 A read accepted in cycle N SHALL set an in-flight flag for cycle N+1.
REQ-029 In cycle N+1 the block SHALL capture sram_dout into a 2-entry response FIFO; rsp_valid first rises in cycle N+2, a 2-cycle latency.
REQ-030 Writes SHALL produce no response; responses SHALL return in request order.
REQ-031 req_ready SHALL be (state==RUN) && (fifo_count + inflight < 2), so a captured read can never overflow the FIFO.
REQ-032 A read accepted in a cycle where a response is popped SHALL use the freed credit only from the next cycle; req_ready depends on registered state only.
REQ-033 A FIFO push and pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-034 rsp_rdata SHALL hold the head entry and stay stable while rsp_valid && !rsp_ready.
REQ-035 A write followed by a read of the same address in the next cycle SHALL return the new data, because the SRAM writes at the first edge.

Reset
REQ-036 Asserting rst SHALL immediately set: state per REQ-019, clear counter=0, in-flight=0, FIFO empty, rsp_valid=0, clear_done=0.
REQ-037 During rst, sram_we and sram_wmask SHALL be 0.
REQ-038 During rst, busy and req_ready SHALL be 0.
REQ-039 Reset mid-clear or mid-read SHALL discard all pending work; a new clear starts at address 0 after release when INIT_ON_RESET=1.

Verification
REQ-040 Reset release, INIT_ON_RESET=1 -> busy=1 for 4096 cycles, sram_addr sweeps 0..4095 with sram_we=1 and sram_din=0, then clear_done pulses once; req_ready=1 in the same cycle.
REQ-041 Write 0xA5 to 0x123, then read 0x123 on the next cycle -> rsp_valid two cycles after the read, rsp_rdata=0xA5.
REQ-042 Back-to-back reads of 0x001, 0x002 and 0x003 with rsp_ready=0 -> req_ready drops after 2 reads; the third is accepted only after the first pop; data returns in order.
REQ-043 rsp_ready toggling 1,0,1 while reads stream -> rsp_rdata stable during stall, no loss, no duplicate.
REQ-044 clear_start while a read is in flight -> ignored; clear_start when idle -> all 4096 addresses read back 0x00.
REQ-045 rst asserted at clear counter=0x800 -> outputs reset asynchronously; after release, clear restarts at 0x000.
